// File: rtl/destruct_sequencer.sv
// -----------------------------------------------------------------------------
// destruct_sequencer
// Central self-destruct sequencer. It qualifies the 2-of-3 threat vote (gated
// by the combat switch) over ARM_TICKS consecutive timebase ticks. It then runs
// an LED countdown that shifts LED_INIT right once every STEP_TICKS ticks. When
// the pattern empties, the block latches the detonate state until reset.
//
// Optional feature macro: DESTRUCT_BLINK_EN
//   defined   -> during the countdown the LEDs blink with a half-period of
//                BLINK_TICKS ticks.
//   undefined -> the LEDs show the pattern steadily and BLINK_TICKS is unused.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset; overrides all other inputs
//   tick         one-clk-wide 10 ms timebase enable
//   in_combat    debounced combat switch
//   danger       debounced danger switch
//   damaged      debounced damaged switch
//   immobilized  debounced immobilized switch
//   abort        level abort request, sampled every clk
//   leds         registered drive for the 8 board LEDs
//   state        FSM state code (0 IDLE, 1 ARMING, 2 COUNTDOWN, 3 DETONATED)
//   detonate     registered; high only in DETONATED
// -----------------------------------------------------------------------------
module destruct_sequencer #(
  parameter int unsigned ARM_TICKS   = 3,
  parameter int unsigned STEP_TICKS  = 100,
  parameter int unsigned BLINK_TICKS = 33,
  parameter logic [7:0]  LED_INIT    = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       in_combat,
  input  logic       danger,
  input  logic       damaged,
  input  logic       immobilized,
  input  logic       abort,
  output logic [7:0] leds,
  output logic [1:0] state,
  output logic       detonate
);

  localparam int unsigned AW = $clog2(ARM_TICKS + 1);
  localparam int unsigned SW = $clog2(STEP_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    COUNTDOWN = 2'd2,
    DETONATED = 2'd3
  } state_t;

  state_t         st;
  logic [7:0]     pattern;
  logic [AW-1:0]  arm_cnt;
  logic [SW-1:0]  step_cnt;
  logic           phase;
  logic           threat;
  logic           qual;
  logic           cd_abort;
  logic [7:0]     pattern_shr;

  assign threat      = (danger & damaged) | (danger & immobilized) | (damaged & immobilized);
  assign qual        = in_combat & threat;
  // Leaving combat on a tick cancels the countdown just like an abort does.
  assign cd_abort    = abort | (tick & ~in_combat);
  assign pattern_shr = pattern >> 1;
  assign state       = st;

`ifdef DESTRUCT_BLINK_EN
  localparam int unsigned BW = $clog2(BLINK_TICKS + 1);
  logic [BW-1:0] blink_cnt;

  // The blink timer only runs inside COUNTDOWN. It is held at its start value
  // everywhere else, so each countdown begins with the LEDs lit.
  always_ff @(posedge clk) begin
    if (rst || st != COUNTDOWN) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (tick) begin
      if (blink_cnt == BW'(BLINK_TICKS - 1)) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end
`else
  logic unused_blink_cfg;
  assign phase            = 1'b1;
  assign unused_blink_cfg = (BLINK_TICKS != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      leds     <= 8'h00;
      detonate <= 1'b0;
      pattern  <= LED_INIT;
      arm_cnt  <= '0;
      step_cnt <= '0;
    end else begin
      case (st)
        IDLE: begin
          leds     <= 8'h00;
          detonate <= 1'b0;
          if (tick && qual) begin
            if (ARM_TICKS == 1) begin
              st       <= COUNTDOWN;
              pattern  <= LED_INIT;
              step_cnt <= '0;
              arm_cnt  <= '0;
            end else begin
              st      <= ARMING;
              arm_cnt <= AW'(1);
            end
          end
        end

        ARMING: begin
          leds <= 8'h00;
          if (abort) begin
            st      <= IDLE;
            arm_cnt <= '0;
          end else if (tick) begin
            if (!qual) begin
              st      <= IDLE;
              arm_cnt <= '0;
            end else if (arm_cnt == AW'(ARM_TICKS - 1)) begin
              st       <= COUNTDOWN;
              pattern  <= LED_INIT;
              step_cnt <= '0;
              arm_cnt  <= '0;
            end else begin
              arm_cnt <= arm_cnt + AW'(1);
            end
          end
        end

        COUNTDOWN: begin
          // Abort is checked first, so it wins over a step or a detonation
          // that falls in the same cycle.
          if (cd_abort) begin
            st       <= IDLE;
            leds     <= 8'h00;
            pattern  <= LED_INIT;
            step_cnt <= '0;
          end else begin
            leds <= phase ? pattern : 8'h00;
            if (tick) begin
              if (step_cnt == SW'(STEP_TICKS - 1)) begin
                step_cnt <= '0;
                pattern  <= pattern_shr;
                if (pattern_shr == 8'h00) begin
                  st       <= DETONATED;
                  detonate <= 1'b1;
                  leds     <= 8'hFF;
                end
              end else begin
                step_cnt <= step_cnt + SW'(1);
              end
            end
          end
        end

        DETONATED: begin
          leds     <= 8'hFF;
          detonate <= 1'b1;
        end

        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_destruct_sequencer.sv
module tb_destruct_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       in_combat;
  logic       danger;
  logic       damaged;
  logic       immobilized;
  logic       abort;
  logic [7:0] leds;
  logic [1:0] state;
  logic       detonate;

  int pass_cnt = 0;
  int total    = 0;

  typedef struct packed {
    logic [1:0] st;
    logic [7:0] leds;
    logic       det;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  destruct_sequencer #(
    .ARM_TICKS  (3),
    .STEP_TICKS (4),
    .BLINK_TICKS(2),
    .LED_INIT   (8'hFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .in_combat  (in_combat),
    .danger     (danger),
    .damaged    (damaged),
    .immobilized(immobilized),
    .abort      (abort),
    .leds       (leds),
    .state      (state),
    .detonate   (detonate)
  );

  // Expected LEDs after the k-th countdown tick (STEP_TICKS=4, BLINK_TICKS=2).
  function automatic logic [7:0] exp_leds(input int k);
    logic [7:0] p;
    p = 8'hFF;
    p = p >> (k / 4);
`ifdef DESTRUCT_BLINK_EN
    if (((k / 2) % 2) == 1) p = 8'h00;
`endif
    return p;
  endfunction

  task automatic tick_pulse();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic idle_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; tick = 1'b0; abort = 1'b0;
    in_combat = 1'b0; danger = 1'b0; damaged = 1'b0; immobilized = 1'b0;
    idle_clks(2);
    rst = 1'b0;
    idle_clks(1);
  endtask

  task automatic set_qual();
    in_combat = 1'b1; danger = 1'b1; damaged = 1'b1; immobilized = 1'b0;
  endtask

  task automatic arm();
    set_qual();
    repeat (3) begin
      tick_pulse();
      idle_clks(3);
    end
  endtask

  task automatic run_ticks(input int n);
    repeat (n) begin
      tick_pulse();
      idle_clks(3);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state);
    else pass_cnt++;
    total++;
    if (leds !== 8'h00) $display("FAIL reset_leds: got %h expected 00", leds);
    else pass_cnt++;
    total++;
    if (detonate !== 1'b0) $display("FAIL reset_detonate: got %b expected 0", detonate);
    else pass_cnt++;
  endtask

  task automatic test_arming();
    do_reset();
    set_qual();
    tick_pulse();
    total++;
    if (state !== 2'd1) $display("FAIL arm_tick1: got %0d expected 1", state);
    else pass_cnt++;
    idle_clks(3);
    tick_pulse();
    total++;
    if (state !== 2'd1) $display("FAIL arm_tick2: got %0d expected 1", state);
    else pass_cnt++;
    idle_clks(3);
    tick_pulse();
    total++;
    if (state !== 2'd2 || leds !== 8'h00)
      $display("FAIL arm_tick3: got state %0d leds %h expected state 2 leds 00", state, leds);
    else pass_cnt++;
    idle_clks(1);
    total++;
    if (leds !== 8'hFF) $display("FAIL arm_leds_lag: got %h expected FF", leds);
    else pass_cnt++;
    idle_clks(2);
  endtask

  task automatic test_arming_drop();
    do_reset();
    set_qual();
    run_ticks(2);
    total++;
    if (state !== 2'd1) $display("FAIL drop_pre: got %0d expected 1", state);
    else pass_cnt++;
    damaged = 1'b0;
    tick_pulse();
    total++;
    if (state !== 2'd0 || leds !== 8'h00)
      $display("FAIL drop_idle: got state %0d leds %h expected state 0 leds 00", state, leds);
    else pass_cnt++;
    idle_clks(3);
    tick_pulse();
    idle_clks(3);
    total++;
    if (state !== 2'd0) $display("FAIL drop_stay: got %0d expected 0", state);
    else pass_cnt++;
  endtask

  task automatic test_countdown();
    exp_t e;
    exp_t got;
    do_reset();
    arm();
    for (int k = 1; k <= 32; k++) begin
      if (k < 32) sb.push_back('{st: 2'd2, leds: exp_leds(k), det: 1'b0});
      else        sb.push_back('{st: 2'd3, leds: 8'hFF, det: 1'b1});
      tick_pulse();
      idle_clks(3);
      e   = sb.pop_front();
      got = '{st: state, leds: leds, det: detonate};
      total++;
      if (got !== e)
        $display("FAIL countdown_k%0d: got st %0d leds %h det %b expected st %0d leds %h det %b",
                 k, got.st, got.leds, got.det, e.st, e.leds, e.det);
      else pass_cnt++;
    end
    abort = 1'b1;
    tick_pulse();
    idle_clks(2);
    abort = 1'b0;
    total++;
    if (state !== 2'd3 || detonate !== 1'b1 || leds !== 8'hFF)
      $display("FAIL detonated_hold: got st %0d det %b leds %h expected st 3 det 1 leds FF",
               state, detonate, leds);
    else pass_cnt++;
  endtask

  task automatic test_abort_race();
    do_reset();
    arm();
    run_ticks(31);
    abort = 1'b1;
    tick_pulse();
    total++;
    if (state !== 2'd0 || detonate !== 1'b0 || leds !== 8'h00)
      $display("FAIL abort_race: got st %0d det %b leds %h expected st 0 det 0 leds 00",
               state, detonate, leds);
    else pass_cnt++;
    abort = 1'b0;
    idle_clks(3);
    arm();
    total++;
    if (state !== 2'd2 || leds !== 8'hFF)
      $display("FAIL abort_rearm: got st %0d leds %h expected st 2 leds FF", state, leds);
    else pass_cnt++;
  endtask

  task automatic test_combat_drop();
    do_reset();
    arm();
    run_ticks(5);
    in_combat = 1'b0;
    tick_pulse();
    total++;
    if (state !== 2'd0 || leds !== 8'h00)
      $display("FAIL combat_drop: got st %0d leds %h expected st 0 leds 00", state, leds);
    else pass_cnt++;
    idle_clks(3);
    arm();
    run_ticks(2);
    abort = 1'b1;
    idle_clks(1);
    abort = 1'b0;
    total++;
    if (state !== 2'd0 || leds !== 8'h00)
      $display("FAIL abort_no_tick: got st %0d leds %h expected st 0 leds 00", state, leds);
    else pass_cnt++;
  endtask

  task automatic test_blink();
    logic [7:0] exp2;
    logic [7:0] exp6;
`ifdef DESTRUCT_BLINK_EN
    exp2 = 8'h00;
    exp6 = 8'h00;
`else
    exp2 = 8'hFF;
    exp6 = 8'h7F;
`endif
    do_reset();
    arm();
    run_ticks(2);
    total++;
    if (leds !== exp2) $display("FAIL blink_k2: got %h expected %h", leds, exp2);
    else pass_cnt++;
    run_ticks(2);
    total++;
    if (leds !== 8'h7F) $display("FAIL blink_k4: got %h expected 7F", leds);
    else pass_cnt++;
    run_ticks(2);
    total++;
    if (leds !== exp6) $display("FAIL blink_k6: got %h expected %h", leds, exp6);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    arm();
    run_ticks(17);
    total++;
    if (leds !== exp_leds(17) || state !== 2'd2)
      $display("FAIL mid_pre: got st %0d leds %h expected st 2 leds %h", state, leds, exp_leds(17));
    else pass_cnt++;
    rst = 1'b1;
    idle_clks(1);
    total++;
    if (state !== 2'd0 || leds !== 8'h00 || detonate !== 1'b0)
      $display("FAIL mid_reset: got st %0d leds %h det %b expected st 0 leds 00 det 0",
               state, leds, detonate);
    else pass_cnt++;
    rst = 1'b0;
    idle_clks(1);
    arm();
    total++;
    if (state !== 2'd2 || leds !== 8'hFF)
      $display("FAIL mid_rearm: got st %0d leds %h expected st 2 leds FF", state, leds);
    else pass_cnt++;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; tick = 1'b0; abort = 1'b0;
    in_combat = 1'b0; danger = 1'b0; damaged = 1'b0; immobilized = 1'b0;
    @(negedge clk);
    test_reset();
    test_arming();
    test_arming_drop();
    test_countdown();
    test_abort_race();
    test_combat_drop();
    test_blink();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
